// File: rtl/noekeon_pkg.sv
// Shared types and the Noekeon primitive transforms (Theta, Pi1, Pi2, Gamma) plus
// the round-constant steppers used by the iterative core.
package noekeon_pkg;

  typedef enum logic [2:0] {IDLE, KEYPREP, ROUND, FINAL, DONE} state_t;
  typedef logic [127:0] block_t;

  localparam logic [7:0] RC_POLY = 8'h1B;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return rotl(x, 32 - n);
  endfunction

  // Word 0 is the most significant word of the 128-bit block.
  function automatic block_t theta(input block_t k, input block_t s);
    logic [31:0] a0, a1, a2, a3, t;
    {a0, a1, a2, a3} = s;
    t  = a0 ^ a2;
    t  = t ^ rotl(t, 8) ^ rotl(t, 24);
    a1 = a1 ^ t;
    a3 = a3 ^ t;
    a0 = a0 ^ k[127:96];
    a1 = a1 ^ k[95:64];
    a2 = a2 ^ k[63:32];
    a3 = a3 ^ k[31:0];
    t  = a1 ^ a3;
    t  = t ^ rotl(t, 8) ^ rotl(t, 24);
    a0 = a0 ^ t;
    a2 = a2 ^ t;
    return {a0, a1, a2, a3};
  endfunction

  function automatic block_t pi1(input block_t s);
    return {s[127:96], rotl(s[95:64], 1), rotl(s[63:32], 5), rotl(s[31:0], 2)};
  endfunction

  function automatic block_t pi2(input block_t s);
    return {s[127:96], rotr(s[95:64], 1), rotr(s[63:32], 5), rotr(s[31:0], 2)};
  endfunction

  function automatic block_t gamma(input block_t s);
    logic [31:0] a0, a1, a2, a3, t;
    {a0, a1, a2, a3} = s;
    a1 = a1 ^ (~a3 & ~a2);
    a0 = a0 ^ (a2 & a1);
    t  = a3;
    a3 = a0;
    a0 = t;
    a2 = a2 ^ a0 ^ a1 ^ a3;
    a1 = a1 ^ (~a3 & ~a2);
    a0 = a0 ^ (a2 & a1);
    return {a0, a1, a2, a3};
  endfunction

  function automatic logic [7:0] rc_fwd(input logic [7:0] rc);
    return {rc[6:0], 1'b0} ^ (rc[7] ? RC_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] rc_bwd(input logic [7:0] rc);
    return rc[0] ? ({1'b0, rc[7:1] ^ 7'h0D} | 8'h80) : {1'b0, rc[7:1]};
  endfunction

  function automatic logic [7:0] rc_at(input logic [7:0] init, input int n);
    logic [7:0] r;
    r = init;
    for (int i = 0; i < n; i++) r = rc_fwd(r);
    return r;
  endfunction

endpackage

// File: rtl/noekeon_round_unit.sv
// One combinational Noekeon round; LAST=1 gives the closing transform (no Pi/Gamma).
module noekeon_round_unit import noekeon_pkg::*; #(
  parameter bit LAST = 1'b0
) (
  input  block_t     state_in,
  input  block_t     key,
  input  logic [7:0] c1,
  input  logic [7:0] c2,
  output block_t     state_out
);

  block_t mixed;

  always_comb begin
    mixed = state_in ^ {24'h0, c1, 96'h0};
    mixed = theta(key, mixed);
    mixed = mixed ^ {24'h0, c2, 96'h0};
  end

  if (LAST) begin : g_last
    assign state_out = mixed;
  end else begin : g_full
    assign state_out = pi2(gamma(pi1(mixed)));
  end

endmodule

// File: rtl/noekeon_iter_core.sv
// Iterative Noekeon-128 engine: UNROLL rounds per clock around a state register,
// with a bidirectional round-constant generator and valid/ready on both sides.
module noekeon_iter_core import noekeon_pkg::*; #(
  parameter int         ROUNDS  = 16,
  parameter int         UNROLL  = 1,
  parameter logic [7:0] RC_INIT = 8'h80
) (
  input  logic         inClk,
  input  logic         inRst,
  input  logic         inValid,
  output logic         outReady,
  input  logic         inDecrypt,
  input  logic [127:0] inDataKey,
  input  logic [127:0] inDataState,
  output logic         outValid,
  input  logic         inReady,
  output logic [127:0] outDataState,
  output logic         outBusy
);

  localparam int         CW     = $clog2(ROUNDS + 1);
  localparam logic [7:0] RC_DEC = rc_at(RC_INIT, ROUNDS);

  state_t        fsm;
  block_t        state_q, key_q, result_q, final_out;
  logic [CW-1:0] cnt_q;
  logic [7:0]    rc_q, fin_c1, fin_c2;
  logic          decrypt_q, valid_q;

  // Each stage consumes the previous stage's state and constant, so one clock covers UNROLL rounds.
  for (genvar i = 0; i < UNROLL; i++) begin : g_round
    block_t     s_in, s_out;
    logic [7:0] rc_in, rc_out, c1, c2;
    if (i == 0) begin : g_first
      assign s_in  = state_q;
      assign rc_in = rc_q;
    end else begin : g_next
      assign s_in  = g_round[i-1].s_out;
      assign rc_in = g_round[i-1].rc_out;
    end
    assign c1     = decrypt_q ? 8'h00 : rc_in;
    assign c2     = decrypt_q ? rc_in : 8'h00;
    assign rc_out = decrypt_q ? rc_bwd(rc_in) : rc_fwd(rc_in);
    noekeon_round_unit #(.LAST(1'b0)) u_round (
      .state_in(s_in), .key(key_q), .c1(c1), .c2(c2), .state_out(s_out)
    );
  end

  assign fin_c1 = decrypt_q ? 8'h00 : rc_q;
  assign fin_c2 = decrypt_q ? rc_q : 8'h00;

  noekeon_round_unit #(.LAST(1'b1)) u_final (
    .state_in(state_q), .key(key_q), .c1(fin_c1), .c2(fin_c2), .state_out(final_out)
  );

  always_ff @(posedge inClk) begin
    if (inRst) begin
      fsm       <= IDLE;
      state_q   <= '0;
      key_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      rc_q      <= '0;
      decrypt_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      case (fsm)
        IDLE: if (inValid) begin
          state_q   <= inDataState;
          key_q     <= inDataKey;
          decrypt_q <= inDecrypt;
          cnt_q     <= '0;
          rc_q      <= inDecrypt ? RC_DEC : RC_INIT;
          fsm       <= inDecrypt ? KEYPREP : ROUND;
        end
        KEYPREP: begin
          key_q <= theta('0, key_q);
          fsm   <= ROUND;
        end
        ROUND: begin
          state_q <= g_round[UNROLL-1].s_out;
          rc_q    <= g_round[UNROLL-1].rc_out;
          cnt_q   <= cnt_q + CW'(UNROLL);
          if (cnt_q + CW'(UNROLL) == CW'(ROUNDS)) fsm <= FINAL;
        end
        FINAL: begin
          result_q <= final_out;
          valid_q  <= 1'b1;
          fsm      <= DONE;
        end
        DONE: if (inReady) begin
          valid_q <= 1'b0;
          fsm     <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign outReady     = (fsm == IDLE);
  assign outBusy      = (fsm != IDLE);
  assign outValid     = valid_q;
  assign outDataState = result_q;

endmodule

// File: tb/tb_noekeon_iter_core.sv
// Self-checking bench for noekeon_iter_core: known vectors, random round trips against
// a word-level reference model, an UNROLL=4 instance, backpressure and mid-run reset.
module tb_noekeon_iter_core;

  typedef logic [0:3][31:0] w4_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         valid = 1'b0, valid4 = 1'b0;
  logic         ready = 1'b0, ready4 = 1'b0;
  logic         decrypt = 1'b0;
  logic [127:0] key = '0, data = '0;
  logic         out_ready, out_valid, out_busy;
  logic         out_ready4, out_valid4, out_busy4;
  logic [127:0] out_data, out_data4;

  int passed = 0;
  int total  = 0;

  localparam logic [127:0] V1 = 128'hb1656851699e29fa24b70148503d2dfc;
  localparam logic [127:0] V2 = 128'h2a78421b87c7d0924f26113f1d1349b2;
  localparam logic [127:0] V3 = 128'he2f687e07b75660ffc372233bc47532c;

  noekeon_iter_core dut (
    .inClk(clk), .inRst(rst), .inValid(valid), .outReady(out_ready),
    .inDecrypt(decrypt), .inDataKey(key), .inDataState(data),
    .outValid(out_valid), .inReady(ready), .outDataState(out_data), .outBusy(out_busy)
  );

  noekeon_iter_core #(.UNROLL(4)) dut4 (
    .inClk(clk), .inRst(rst), .inValid(valid4), .outReady(out_ready4),
    .inDecrypt(decrypt), .inDataKey(key), .inDataState(data),
    .outValid(out_valid4), .inReady(ready4), .outDataState(out_data4), .outBusy(out_busy4)
  );

  always #5 clk = ~clk;

  // Reference model, written directly from the cipher's word-level description.
  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic w4_t m_theta(input w4_t k, input w4_t a);
    logic [31:0] t;
    t = a[0] ^ a[2]; t = t ^ rl(t, 8) ^ rl(t, 24);
    a[1] ^= t; a[3] ^= t;
    for (int i = 0; i < 4; i++) a[i] ^= k[i];
    t = a[1] ^ a[3]; t = t ^ rl(t, 8) ^ rl(t, 24);
    a[0] ^= t; a[2] ^= t;
    return a;
  endfunction

  function automatic w4_t m_round(input w4_t k, input w4_t a, input logic [31:0] c1, input logic [31:0] c2);
    logic [31:0] t;
    a[0] ^= c1;
    a = m_theta(k, a);
    a[0] ^= c2;
    a[1] = rl(a[1], 1); a[2] = rl(a[2], 5); a[3] = rl(a[3], 2);
    a[1] ^= ~a[3] & ~a[2];
    a[0] ^= a[2] & a[1];
    t = a[3]; a[3] = a[0]; a[0] = t;
    a[2] ^= a[0] ^ a[1] ^ a[3];
    a[1] ^= ~a[3] & ~a[2];
    a[0] ^= a[2] & a[1];
    a[1] = rl(a[1], 31); a[2] = rl(a[2], 27); a[3] = rl(a[3], 30);
    return a;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] k_in, input logic [127:0] d_in, input bit dec);
    w4_t k = k_in;
    w4_t a = d_in;
    w4_t z = '0;
    int  rcs [17];
    rcs[0] = 32'h80;
    for (int i = 1; i <= 16; i++) begin
      rcs[i] = rcs[i-1] * 2;
      if (rcs[i] > 255) rcs[i] = rcs[i] ^ 32'h11B;
    end
    if (!dec) begin
      for (int r = 0; r < 16; r++) a = m_round(k, a, rcs[r], 0);
      a[0] ^= rcs[16];
      a = m_theta(k, a);
    end else begin
      k = m_theta(z, k);
      for (int r = 0; r < 16; r++) a = m_round(k, a, 0, rcs[16-r]);
      a = m_theta(k, a);
      a[0] ^= rcs[0];
    end
    return a;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Drives one request into the UNROLL=1 core and collects the result; lat=-1 on timeout.
  task automatic run_txn(input logic [127:0] k, input logic [127:0] d, input logic dec,
                         output logic [127:0] res, output int lat);
    key = k; data = d; decrypt = dec; valid = 1'b1;
    step();
    valid = 1'b0; lat = -1; res = '0;
    for (int n = 1; n <= 100; n++) begin
      step();
      if (out_valid) begin lat = n; res = out_data; break; end
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", out_valid); else passed++;
    total++; if (out_data !== 128'h0) $display("[TB] FAIL reset_data: got %h want 0", out_data); else passed++;
    total++; if (out_busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", out_busy); else passed++;
    total++; if (out_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b want 1", out_ready); else passed++;
    total++; if (out_ready4 !== 1'b1) $display("[TB] FAIL reset_ready4: got %b want 1", out_ready4); else passed++;
  endtask

  task automatic test_vectors();
    logic [127:0] keys [3] = '{128'h0, {128{1'b1}}, V1};
    logic [127:0] dats [3] = '{128'h0, {128{1'b1}}, V2};
    logic [127:0] exps [3] = '{V1, V2, V3};
    logic [127:0] res;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_txn(keys[i], dats[i], 1'b0, res, lat);
      total++; if (res !== exps[i]) $display("[TB] FAIL kat_enc%0d: got %h want %h", i, res, exps[i]); else passed++;
      total++; if (lat != 17) $display("[TB] FAIL kat_enc_lat%0d: got %0d want 17", i, lat); else passed++;
    end
    run_txn(V1, V3, 1'b1, res, lat);
    total++; if (res !== V2) $display("[TB] FAIL kat_dec: got %h want %h", res, V2); else passed++;
    total++; if (lat != 18) $display("[TB] FAIL kat_dec_lat: got %0d want 18", lat); else passed++;
  endtask

  task automatic test_random();
    logic [127:0] k, d, ct, pt, exp;
    int lat;
    for (int i = 0; i < 4; i++) begin
      k = rnd128(); d = rnd128();
      exp = model(k, d, 1'b0);
      run_txn(k, d, 1'b0, ct, lat);
      total++; if (ct !== exp) $display("[TB] FAIL rand_enc%0d: got %h want %h", i, ct, exp); else passed++;
      total++; if (lat != 17) $display("[TB] FAIL rand_enc_lat%0d: got %0d want 17", i, lat); else passed++;
      run_txn(k, exp, 1'b1, pt, lat);
      total++; if (pt !== d) $display("[TB] FAIL rand_dec%0d: got %h want %h", i, pt, d); else passed++;
      total++; if (lat != 18) $display("[TB] FAIL rand_dec_lat%0d: got %0d want 18", i, lat); else passed++;
    end
  endtask

  task automatic test_unroll();
    logic [127:0] keys [4] = '{128'h0, {128{1'b1}}, V1, V1};
    logic [127:0] dats [4] = '{128'h0, {128{1'b1}}, V2, V3};
    logic [127:0] exps [4] = '{V1, V2, V3, V2};
    int lat, want;
    for (int i = 0; i < 4; i++) begin
      key = keys[i]; data = dats[i]; decrypt = (i == 3); valid4 = 1'b1;
      want = (i == 3) ? 6 : 5;
      step();
      valid4 = 1'b0; lat = -1;
      for (int n = 1; n <= 100; n++) begin
        step();
        if (out_valid4) begin lat = n; break; end
      end
      total++; if (out_data4 !== exps[i]) $display("[TB] FAIL unroll4_data%0d: got %h want %h", i, out_data4, exps[i]); else passed++;
      total++; if (lat != want) $display("[TB] FAIL unroll4_lat%0d: got %0d want %0d", i, lat, want); else passed++;
      ready4 = 1'b1; step(); ready4 = 1'b0;
    end
    decrypt = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [127:0] k, d, exp;
    int lat;
    k = rnd128(); d = rnd128();
    exp = model(k, d, 1'b0);
    key = k; data = d; decrypt = 1'b0; valid = 1'b1;
    step();
    valid = 1'b0; lat = -1;
    for (int n = 1; n <= 100; n++) begin
      step();
      if (out_valid) begin lat = n; break; end
    end
    total++; if (lat != 17) $display("[TB] FAIL bp_lat: got %0d want 17", lat); else passed++;
    for (int c = 0; c < 5; c++) begin
      valid = 1'b1; key = rnd128(); data = rnd128(); decrypt = c[0];
      step();
      total++; if (out_data !== exp) $display("[TB] FAIL bp_hold_data%0d: got %h want %h", c, out_data, exp); else passed++;
      total++; if (out_ready !== 1'b0) $display("[TB] FAIL bp_hold_ready%0d: got %b want 0", c, out_ready); else passed++;
      total++; if (out_valid !== 1'b1) $display("[TB] FAIL bp_hold_valid%0d: got %b want 1", c, out_valid); else passed++;
    end
    valid = 1'b0; decrypt = 1'b0; ready = 1'b1;
    step();
    ready = 1'b0;
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL bp_release_valid: got %b want 0", out_valid); else passed++;
    total++; if (out_ready !== 1'b1) $display("[TB] FAIL bp_release_ready: got %b want 1", out_ready); else passed++;
    step();
    total++; if (out_busy !== 1'b0) $display("[TB] FAIL bp_no_accept: got busy %b want 0", out_busy); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [127:0] res;
    int lat;
    key = rnd128(); data = rnd128(); decrypt = 1'b0; valid = 1'b1;
    step();
    valid = 1'b0;
    for (int c = 0; c < 8; c++) step();
    total++; if (out_busy !== 1'b1) $display("[TB] FAIL mid_busy: got %b want 1", out_busy); else passed++;
    rst = 1'b1; step(); rst = 1'b0;
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL mid_rst_valid: got %b want 0", out_valid); else passed++;
    total++; if (out_data !== 128'h0) $display("[TB] FAIL mid_rst_data: got %h want 0", out_data); else passed++;
    total++; if (out_ready !== 1'b1) $display("[TB] FAIL mid_rst_ready: got %b want 1", out_ready); else passed++;
    total++; if (out_busy !== 1'b0) $display("[TB] FAIL mid_rst_busy: got %b want 0", out_busy); else passed++;
    run_txn(128'h0, 128'h0, 1'b0, res, lat);
    total++; if (res !== V1) $display("[TB] FAIL mid_rst_after: got %h want %h", res, V1); else passed++;
    total++; if (lat != 17) $display("[TB] FAIL mid_rst_after_lat: got %0d want 17", lat); else passed++;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_unroll();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
